// File: rtl/mult_div_unit_pkg.sv
// Shared op-code and FSM state encodings for the iterative multiply/divide unit.
// The ID-stage decoder imports the same op-code constants.
package mult_div_unit_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_FIX  = 2'b11
    } state_t;

endpackage

// File: rtl/mdu_iter_core.sv
// Unsigned iterative datapath: radix-2 shift-add multiply (mode=0) or restoring
// shift-subtract divide (mode=1). acc ends as HI/remainder, q as LO/quotient.
module mdu_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             mode,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] m;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // diff[WIDTH] is the borrow: set means the trial subtraction must be undone
    always_comb begin
        sum     = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
        shifted = {acc, q[WIDTH-1]};
        diff    = shifted - {1'b0, m};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            q   <= '0;
            m   <= '0;
        end else if (load) begin
            acc <= '0;
            q   <= a;
            m   <= b;
        end else if (step) begin
            if (!mode) begin
                {acc, q} <= {sum, q[WIDTH-1:1]};
            end else if (!diff[WIDTH]) begin
                acc <= diff[WIDTH-1:0];
                q   <= {q[WIDTH-2:0], 1'b1};
            end else begin
                acc <= shifted[WIDTH-1:0];
                q   <= {q[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit: FSM, iteration counter, sign handling and HI/LO.
//   state  | meaning
//   S_IDLE | waiting; accepts MUL/DIV/MTHI/MTLO
//   S_MUL  | WIDTH shift-add iterations in flight
//   S_DIV  | WIDTH shift-subtract iterations in flight
//   S_FIX  | sign correction, HI/LO written on leaving
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt;

    logic accept_md, accept_div, wr_hi, wr_lo, core_step, fix_write;
    logic is_signed, neg_a, neg_b;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic res_neg, rem_neg, div0, op_div;

    logic [WIDTH-1:0]   acc, q;
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0]   hi_fix, lo_fix;

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        accept_md  = 1'b0;
        accept_div = 1'b0;
        wr_hi      = 1'b0;
        wr_lo      = 1'b0;
        core_step  = 1'b0;
        fix_write  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            accept_md = 1'b1;
                            state_nxt = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            accept_md  = 1'b1;
                            accept_div = 1'b1;
                            state_nxt  = S_DIV;
                        end
                        OP_MTHI: wr_hi = 1'b1;
                        OP_MTLO: wr_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_MUL, S_DIV: begin
                core_step = 1'b1;
                if (cnt == CNT_W'(1)) state_nxt = S_FIX;
            end
            S_FIX: begin
                fix_write = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // a flush discards whatever this edge would otherwise have done
        if (cancel) begin
            state_nxt  = S_IDLE;
            accept_md  = 1'b0;
            accept_div = 1'b0;
            wr_hi      = 1'b0;
            wr_lo      = 1'b0;
            core_step  = 1'b0;
            fix_write  = 1'b0;
        end
    end

    always_comb begin
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        neg_a     = is_signed & in1[WIDTH-1];
        neg_b     = is_signed & in2[WIDTH-1];
        a_mag     = neg_a ? -in1 : in1;
        b_mag     = neg_b ? -in2 : in2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            div0    <= 1'b0;
            op_div  <= 1'b0;
        end else if (cancel) begin
            cnt <= '0;
        end else if (accept_md) begin
            cnt     <= CNT_W'(WIDTH);
            res_neg <= neg_a ^ neg_b;
            rem_neg <= neg_a;
            div0    <= accept_div && (in2 == '0);
            op_div  <= accept_div;
        end else if (core_step) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    mdu_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk  (clk),
        .rst  (rst),
        .load (accept_md),
        .mode (state == S_DIV),
        .step (core_step),
        .a    (a_mag),
        .b    (b_mag),
        .acc  (acc),
        .q    (q)
    );

    // divide-by-zero: remainder path restores in1 from |in1|, quotient is forced
    always_comb begin
        prod_raw = {acc, q};
        prod_fix = res_neg ? -prod_raw : prod_raw;
        if (op_div) begin
            lo_fix = div0 ? '1 : (res_neg ? -q : q);
            hi_fix = rem_neg ? -acc : acc;
        end else begin
            lo_fix = prod_fix[WIDTH-1:0];
            hi_fix = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= fix_write;
            if (wr_hi) hi <= in1;
            if (wr_lo) lo <= in1;
            if (fix_write) begin
                hi <= hi_fix;
                lo <= lo_fix;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written
// multi-cycle sequences, and random MUL/DIV ops against an arithmetic model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst, start, cancel;
    logic [2:0]  op;
    logic [31:0] in1, in2;
    logic        busy, done;
    logic [31:0] hi, lo;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t tbl[8];

    mult_div_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .in1(in1), .in2(in2),
        .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference result {hi,lo} from plain arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        int     qs, rs;
        logic [63:0] r;
        r = '0;
        case (o)
            3'd1: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                r  = 64'(sa * sb);
            end
            3'd2: r = {32'd0, a} * {32'd0, b};
            3'd3: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
                else begin
                    qs = $signed(a) / $signed(b);
                    rs = $signed(a) % $signed(b);
                    r  = {32'(rs), 32'(qs)};
                end
            end
            3'd4: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else        r = {a % b, a / b};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic wait_idle(output int busy_cycles, output int done_cnt);
        int guard = 0;
        busy_cycles = 0;
        done_cnt    = 0;
        while (busy === 1'b1 && guard < 100) begin
            busy_cycles++;
            if (done === 1'b1) done_cnt++;
            @(negedge clk);
            guard++;
        end
        if (done === 1'b1) done_cnt++;
    endtask

    // Issue one mul/div op and check latency, done pulse and result. Inputs are
    // scrambled right after the accepting edge to confirm operands are latched.
    task automatic run_md(input string nm, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        int bc, dc;
        @(negedge clk);
        start = 1'b1; op = o; in1 = a; in2 = b;
        @(negedge clk);
        start = 1'b0; op = 3'($urandom_range(0, 7)); in1 = $urandom; in2 = $urandom;
        wait_idle(bc, dc);
        @(negedge clk);
        if (done === 1'b1) dc++;
        check({nm, ".busy_cycles"}, 64'(bc), 64'd33);
        check({nm, ".done_pulses"}, 64'(dc), 64'd1);
        check({nm, ".hi"}, {32'd0, hi}, {32'd0, exp[63:32]});
        check({nm, ".lo"}, {32'd0, lo}, {32'd0, exp[31:0]});
    endtask

    task automatic move_to(input logic [2:0] o, input logic [31:0] v);
        @(negedge clk);
        start = 1'b1; op = o; in1 = v;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int bc, dc;
        logic [31:0] hsave, lsave;
        logic [63:0] r;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        tbl[0] = '{"mult_neg3x7",   3'd1, 32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB};
        tbl[1] = '{"multu_max",     3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
        tbl[2] = '{"div_neg7by2",   3'd3, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[3] = '{"divu_7by0",     3'd4, 32'd7,         32'd0,          32'd7,         32'hFFFF_FFFF};
        tbl[4] = '{"div_overflow",  3'd3, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0,         32'h8000_0000};
        tbl[5] = '{"div_neg5by0",   3'd3, 32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFB, 32'hFFFF_FFFF};
        tbl[6] = '{"divu_100by3",   3'd4, 32'd100,       32'd3,          32'd1,         32'd33};
        tbl[7] = '{"mult_neg_neg",  3'd1, 32'hFFFF_FFFE, 32'h8000_0000,  32'h0000_0001, 32'h0};

        rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 3'd0; in1 = '0; in2 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset.busy", {63'd0, busy}, 64'd0);
        check("reset.done", {63'd0, done}, 64'd0);
        check("reset.hi", {32'd0, hi}, 64'd0);
        check("reset.lo", {32'd0, lo}, 64'd0);

        foreach (tbl[i])
            run_md(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, {tbl[i].hi, tbl[i].lo});

        // MTLO while idle: visible next cycle, never busy
        move_to(3'd6, 32'h0000_1234);
        check("mtlo.lo", {32'd0, lo}, 64'h1234);
        check("mtlo.busy", {63'd0, busy}, 64'd0);
        check("mtlo.done", {63'd0, done}, 64'd0);
        move_to(3'd5, 32'h0000_AAAA);
        check("mthi.hi", {32'd0, hi}, 64'hAAAA);

        // NOP and reserved op with start are ignored
        move_to(3'd0, 32'h1111_1111);
        move_to(3'd7, 32'h2222_2222);
        check("ignored_ops.busy", {63'd0, busy}, 64'd0);
        check("ignored_ops.hi", {32'd0, hi}, 64'hAAAA);
        check("ignored_ops.lo", {32'd0, lo}, 64'h1234);

        // MTHI while busy is ignored
        @(negedge clk);
        start = 1'b1; op = 3'd2; in1 = 32'd6; in2 = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; op = 3'd5; in1 = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        check("mthi_busy.hi", {32'd0, hi}, 64'hAAAA);
        check("mthi_busy.busy", {63'd0, busy}, 64'd1);
        wait_idle(bc, dc);
        check("mthi_busy.final_lo", {32'd0, lo}, 64'd42);
        check("mthi_busy.final_hi", {32'd0, hi}, 64'd0);

        // Cancel mid-DIVU: no write, no done
        move_to(3'd5, 32'h0000_AAAA);
        move_to(3'd6, 32'h0000_5555);
        @(negedge clk);
        start = 1'b1; op = 3'd4; in1 = 32'd100; in2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel.busy", {63'd0, busy}, 64'd0);
        dc = 0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1 || busy === 1'b1) dc++;
            @(negedge clk);
        end
        check("cancel.no_activity", 64'(dc), 64'd0);
        check("cancel.hi", {32'd0, hi}, 64'hAAAA);
        check("cancel.lo", {32'd0, lo}, 64'h5555);

        // cancel together with start in idle: nothing accepted
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; op = 3'd6; in1 = 32'h77;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        check("cancel_start.lo", {32'd0, lo}, 64'h5555);
        start = 1'b1; cancel = 1'b1; op = 3'd1; in1 = 32'd3; in2 = 32'd3;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        check("cancel_start.busy", {63'd0, busy}, 64'd0);

        // Reset mid-MULT clears everything
        @(negedge clk);
        start = 1'b1; op = 3'd1; in1 = 32'd9; in2 = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid.busy", {63'd0, busy}, 64'd0);
        check("rst_mid.hi", {32'd0, hi}, 64'd0);
        check("rst_mid.lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        check("rst_mid.done", {63'd0, done}, 64'd0);

        // Back-to-back: MULTU accepted in the done cycle of a DIV
        @(negedge clk);
        start = 1'b1; op = 3'd3; in1 = 32'd20; in2 = 32'd6;
        @(negedge clk);
        start = 1'b0;
        wait_idle(bc, dc);
        check("b2b.div_done", {63'd0, done}, 64'd1);
        check("b2b.div_lo", {32'd0, lo}, 64'd3);
        start = 1'b1; op = 3'd2; in1 = 32'd3; in2 = 32'd5;
        @(negedge clk);
        start = 1'b0;
        check("b2b.accepted", {63'd0, busy}, 64'd1);
        wait_idle(bc, dc);
        check("b2b.busy_cycles", 64'(bc), 64'd33);
        check("b2b.lo", {32'd0, lo}, 64'd15);
        check("b2b.hi", {32'd0, hi}, 64'd0);

        // Randomized ops against the arithmetic model
        for (int n = 0; n < 40; n++) begin
            ro = 3'($urandom_range(1, 4));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: ra = 32'($urandom_range(0, 100));
                default: ;
            endcase
            r = model(ro, ra, rb);
            run_md($sformatf("rand%0d_op%0d", n, ro), ro, ra, rb, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
